// File: rtl/dtree_seq_engine_pkg.sv
// Shared definitions for the decision-tree sequential engine:
// decoded node-word struct, field-width helper functions and FSM state enum.
// The decoded struct uses fixed, generous field widths; the packed node word
// stored in the table is sized from the engine parameters via node_w().
package dtree_pkg;

  // Decoded-node field widths (upper bound for any legal parameterisation)
  localparam int NT_IDX_W = 16;
  localparam int NT_SH_W  = 8;
  localparam int NT_THR_W = 32;

  // One node-table entry after decoding, all fields zero-extended
  typedef struct packed {
    logic                is_leaf;
    logic [NT_IDX_W-1:0] feat_idx;
    logic [NT_SH_W-1:0]  shift;
    logic [NT_THR_W-1:0] thr;
    logic [NT_IDX_W-1:0] left;
    logic [NT_IDX_W-1:0] right;
  } node_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // feature-index field width
  function automatic int fidx_w(input int n_feat);
    return clog2_min1(n_feat);
  endfunction

  // shift field width (shift amounts 0 .. FEAT_W-1)
  function automatic int shift_w(input int feat_w);
    return clog2_min1(feat_w);
  endfunction

  // child pointer / table address width
  function automatic int ptr_w(input int n_nodes);
    return clog2_min1(n_nodes);
  endfunction

  // step counter / path length width, able to hold max_steps itself
  function automatic int step_w(input int max_steps);
    return clog2_min1(max_steps + 1);
  endfunction

  // packed node word: {is_leaf, feat_idx, shift, thr, left, right}
  function automatic int node_w(input int n_feat, input int feat_w, input int n_nodes);
    return 1 + fidx_w(n_feat) + shift_w(feat_w) + feat_w + 2 * ptr_w(n_nodes);
  endfunction

endpackage

// File: rtl/dtree_seq_engine_node_eval.sv
// Combinational node comparison: select a feature (indices past the last
// feature read as 0), shift it right, compare unsigned against the threshold.
module dtree_node_eval
  import dtree_pkg::*;
#(
  parameter int N_FEAT = 18,
  parameter int FEAT_W = 8
) (
  input  logic [N_FEAT*FEAT_W-1:0] i_feat,
  input  logic [NT_IDX_W-1:0]      i_feat_idx,
  input  logic [NT_SH_W-1:0]       i_shift,
  input  logic [NT_THR_W-1:0]      i_thr,
  output logic                     o_go_left
);

  logic [FEAT_W-1:0]   w_sel;
  logic [NT_THR_W-1:0] w_shifted;

  // One-hot feature mux; no match (out-of-range index) leaves the value at 0
  always_comb begin
    w_sel = {FEAT_W{1'b0}};
    for (int i = 0; i < N_FEAT; i++) begin
      w_sel = w_sel | ((int'(i_feat_idx) == i) ? i_feat[i*FEAT_W +: FEAT_W] : {FEAT_W{1'b0}});
    end
  end

  // Shift then unsigned compare; equal goes left
  always_comb begin
    w_shifted = NT_THR_W'(w_sel) >> i_shift;
    o_go_left = (w_shifted <= i_thr);
  end

endmodule

// File: rtl/dtree_seq_engine.sv
// Sequential decision-tree inference engine. One node evaluated per cycle
// from a reset-initialised node table (every entry a class-0 leaf).
// Optional feature: define DTREE_PATHLEN_EN to add out_pathlen, the number
// of internal nodes visited by the reported traversal.
module dtree_seq_engine
  import dtree_pkg::*;
#(
  parameter int N_FEAT    = 18,
  parameter int FEAT_W    = 8,
  parameter int N_NODES   = 64,
  parameter int CLASS_W   = 2,
  parameter int MAX_STEPS = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [N_FEAT*FEAT_W-1:0]                in_feat,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [CLASS_W-1:0]                      out_class,
  output logic                                    out_err,
  input  logic                                    cfg_we,
  input  logic [ptr_w(N_NODES)-1:0]               cfg_addr,
  input  logic [node_w(N_FEAT,FEAT_W,N_NODES)-1:0] cfg_wdata,
  output logic                                    cfg_busy
`ifdef DTREE_PATHLEN_EN
  ,
  output logic [step_w(MAX_STEPS)-1:0]            out_pathlen
`endif
);

  localparam int FI_W     = fidx_w(N_FEAT);
  localparam int SH_W     = shift_w(FEAT_W);
  localparam int PTR_W    = ptr_w(N_NODES);
  localparam int STEP_W   = step_w(MAX_STEPS);
  localparam int NODE_W   = node_w(N_FEAT, FEAT_W, N_NODES);
  localparam int OFF_LEFT = PTR_W;
  localparam int OFF_THR  = 2 * PTR_W;
  localparam int OFF_SH   = OFF_THR + FEAT_W;
  localparam int OFF_FI   = OFF_SH + SH_W;
  localparam int OFF_LEAF = NODE_W - 1;
  localparam logic [NODE_W-1:0] LEAF0 = {1'b1, {(NODE_W-1){1'b0}}};

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NODE_W-1:0]       r_table [N_NODES];
  logic [N_FEAT*FEAT_W-1:0] r_feat;
  logic [PTR_W-1:0]        r_ptr;
  logic [STEP_W-1:0]       r_step;
  logic [CLASS_W-1:0]      r_class;
  logic                    r_err;
  logic [NODE_W-1:0]       w_word;
  node_t                   w_node;
  logic                    w_go_left;
  logic [NT_IDX_W-1:0]     w_next;
  logic                    w_bad_child;
  logic                    w_step_lim;
  logic                    w_finish;

  assign w_word = r_table[r_ptr];

  // Unpack the current node word into zero-extended fields
  always_comb begin
    w_node          = '0;
    w_node.is_leaf  = w_word[OFF_LEAF];
    w_node.feat_idx = NT_IDX_W'(w_word[OFF_FI +: FI_W]);
    w_node.shift    = NT_SH_W'(w_word[OFF_SH +: SH_W]);
    w_node.thr      = NT_THR_W'(w_word[OFF_THR +: FEAT_W]);
    w_node.left     = NT_IDX_W'(w_word[OFF_LEFT +: PTR_W]);
    w_node.right    = NT_IDX_W'(w_word[0 +: PTR_W]);
  end

  dtree_node_eval #(
    .N_FEAT (N_FEAT),
    .FEAT_W (FEAT_W)
  ) u_node_eval (
    .i_feat     (r_feat),
    .i_feat_idx (w_node.feat_idx),
    .i_shift    (w_node.shift),
    .i_thr      (w_node.thr),
    .o_go_left  (w_go_left)
  );

  // Child selection and abort conditions for the node under evaluation
  always_comb begin
    w_next      = w_go_left ? w_node.left : w_node.right;
    w_bad_child = (int'(w_next) >= N_NODES);
    w_step_lim  = (r_step == STEP_W'(MAX_STEPS));
    w_finish    = w_node.is_leaf | w_step_lim | w_bad_child;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; DONE always returns to IDLE before a new accept
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_state_nxt = ST_WALK;
        else          w_state_nxt = ST_IDLE;
      end
      ST_WALK: begin
        if (w_finish) w_state_nxt = ST_DONE;
        else          w_state_nxt = ST_WALK;
      end
      ST_DONE: begin
        if (out_ready) w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode from the state register
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
    cfg_busy  = (r_state != ST_IDLE);
  end

  // Node table: reset to class-0 leaves, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) begin
        r_table[i] <= LEAF0;
      end
    end else if (cfg_we && (r_state == ST_IDLE)) begin
      r_table[cfg_addr] <= cfg_wdata;
    end
  end

  // Traversal datapath: latch vector, advance pointer, capture result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feat  <= {(N_FEAT*FEAT_W){1'b0}};
      r_ptr   <= {PTR_W{1'b0}};
      r_step  <= {STEP_W{1'b0}};
      r_class <= {CLASS_W{1'b0}};
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_feat <= in_feat;
            r_ptr  <= {PTR_W{1'b0}};
            r_step <= {STEP_W{1'b0}};
          end
        end
        ST_WALK: begin
          if (w_node.is_leaf) begin
            r_class <= w_node.thr[CLASS_W-1:0];
            r_err   <= 1'b0;
          end else if (w_step_lim) begin
            r_class <= {CLASS_W{1'b0}};
            r_err   <= 1'b1;
          end else if (w_bad_child) begin
            r_class <= {CLASS_W{1'b0}};
            r_err   <= 1'b1;
            r_step  <= r_step + STEP_W'(1);
          end else begin
            r_ptr   <= w_next[PTR_W-1:0];
            r_step  <= r_step + STEP_W'(1);
          end
        end
        default: begin
          r_class <= r_class;
        end
      endcase
    end
  end

  assign out_class = r_class;
  assign out_err   = r_err;
`ifdef DTREE_PATHLEN_EN
  assign out_pathlen = r_step;
`endif

endmodule

// File: tb/tb_dtree_seq_engine.sv
// Directed, table-driven bench for dtree_seq_engine (default parameters).
module tb_dtree_seq_engine;

  localparam int N_FEAT    = 18;
  localparam int FEAT_W    = 8;
  localparam int N_NODES   = 64;
  localparam int CLASS_W   = 2;
  localparam int MAX_STEPS = 16;
  localparam int FV        = N_FEAT * FEAT_W;
  localparam int NODE_W    = 29;
  localparam int PTR_W     = 6;
  localparam int PL_W      = 5;
  localparam int N_VEC     = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [FV-1:0]     in_feat;
  logic              out_valid;
  logic              out_ready;
  logic [CLASS_W-1:0] out_class;
  logic              out_err;
  logic              cfg_we;
  logic [PTR_W-1:0]  cfg_addr;
  logic [NODE_W-1:0] cfg_wdata;
  logic              cfg_busy;
`ifdef DTREE_PATHLEN_EN
  logic [PL_W-1:0]   out_pathlen;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NODE_W-1:0]  node0;
    logic [FV-1:0]      feat;
    logic [CLASS_W-1:0] exp_class;
    logic               exp_err;
    int                 exp_lat;
  } vec_t;

  vec_t tbl [N_VEC];

  dtree_seq_engine #(
    .N_FEAT    (N_FEAT),
    .FEAT_W    (FEAT_W),
    .N_NODES   (N_NODES),
    .CLASS_W   (CLASS_W),
    .MAX_STEPS (MAX_STEPS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_busy  (cfg_busy)
`ifdef DTREE_PATHLEN_EN
    ,
    .out_pathlen (out_pathlen)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [NODE_W-1:0] mk_node(input logic leaf, input logic [4:0] fi,
                                                input logic [2:0] sh, input logic [7:0] thr,
                                                input logic [5:0] l, input logic [5:0] r);
    return {leaf, fi, sh, thr, l, r};
  endfunction

  function automatic logic [FV-1:0] fset(input logic [FV-1:0] v, input int idx, input logic [7:0] val);
    logic [FV-1:0] t;
    t = v;
    t[idx*FEAT_W +: FEAT_W] = val;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [NODE_W-1:0] n0, input logic [FV-1:0] f,
                         input logic [CLASS_W-1:0] c, input logic e, input int lat);
    tbl[i].node0     = n0;
    tbl[i].feat      = f;
    tbl[i].exp_class = c;
    tbl[i].exp_err   = e;
    tbl[i].exp_lat   = lat;
  endtask

  task automatic write_node(input logic [PTR_W-1:0] a, input logic [NODE_W-1:0] w);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = w;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [FV-1:0] f);
    @(negedge clk);
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_feat  = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ack_in_ready", 32'(in_ready), 32'd1);
    chk("ack_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    logic seen_valid;
    logic [FV-1:0] f;

    // node0 variants driven by the table; nodes 1..4 are fixed below
    set_vec(0,  mk_node(1'b0, 5'd7, 3'd0, 8'd163, 6'd1, 6'd2), fset('0, 7, 8'd163), 2'd1, 1'b0, 2);
    set_vec(1,  mk_node(1'b0, 5'd7, 3'd0, 8'd163, 6'd1, 6'd2), fset('0, 7, 8'd164), 2'd3, 1'b0, 2);
    set_vec(2,  mk_node(1'b0, 5'd7, 3'd0, 8'd163, 6'd1, 6'd2), fset('0, 7, 8'd0),   2'd1, 1'b0, 2);
    set_vec(3,  mk_node(1'b0, 5'd7, 3'd0, 8'd163, 6'd1, 6'd2), fset('0, 7, 8'd255), 2'd3, 1'b0, 2);
    set_vec(4,  mk_node(1'b0, 5'd17, 3'd3, 8'd10, 6'd1, 6'd2), fset('0, 17, 8'd87), 2'd1, 1'b0, 2);
    set_vec(5,  mk_node(1'b0, 5'd17, 3'd3, 8'd10, 6'd1, 6'd2), fset('0, 17, 8'd88), 2'd3, 1'b0, 2);
    set_vec(6,  mk_node(1'b0, 5'd17, 3'd3, 8'd10, 6'd1, 6'd2), fset('0, 17, 8'd255), 2'd3, 1'b0, 2);
    set_vec(7,  mk_node(1'b0, 5'd0, 3'd0, 8'd0, 6'd0, 6'd0),   fset('0, 0, 8'd0),   2'd0, 1'b1, MAX_STEPS + 1);
    set_vec(8,  mk_node(1'b0, 5'd20, 3'd0, 8'd0, 6'd1, 6'd2),  {FV{1'b1}},          2'd1, 1'b0, 2);
    set_vec(9,  mk_node(1'b0, 5'd0, 3'd0, 8'd0, 6'd1, 6'd2),   fset('0, 0, 8'd1),   2'd3, 1'b0, 2);
    set_vec(10, mk_node(1'b1, 5'd0, 3'd0, 8'h06, 6'd0, 6'd0),  fset('0, 0, 8'd9),   2'd2, 1'b0, 1);
    set_vec(11, mk_node(1'b0, 5'd0, 3'd0, 8'd100, 6'd3, 6'd2), fset(fset('0, 0, 8'd50), 1, 8'd101), 2'd1, 1'b0, 3);
    set_vec(12, mk_node(1'b0, 5'd0, 3'd0, 8'd100, 6'd3, 6'd2), fset(fset('0, 0, 8'd50), 1, 8'd102), 2'd0, 1'b0, 3);
    set_vec(13, mk_node(1'b0, 5'd0, 3'd0, 8'd100, 6'd3, 6'd2), fset('0, 0, 8'd101), 2'd3, 1'b0, 2);

    do_reset();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
`ifdef DTREE_PATHLEN_EN
    chk("rst_pathlen", 32'(out_pathlen), 32'd0);
`endif

    // Reset table: root is a class-0 leaf
    send(fset('0, 3, 8'd77));
    wait_out(lat);
    chk("rst_tbl_lat", 32'(lat), 32'd1);
    chk("rst_tbl_class", 32'(out_class), 32'd0);
    chk("rst_tbl_err", 32'(out_err), 32'd0);
    release_out();

    write_node(6'd1, mk_node(1'b1, 5'd0, 3'd0, 8'd1, 6'd0, 6'd0));
    write_node(6'd2, mk_node(1'b1, 5'd0, 3'd0, 8'd3, 6'd0, 6'd0));
    write_node(6'd3, mk_node(1'b0, 5'd1, 3'd1, 8'd50, 6'd1, 6'd4));
    write_node(6'd4, mk_node(1'b1, 5'd0, 3'd0, 8'hFC, 6'd0, 6'd0));

    for (int i = 0; i < N_VEC; i++) begin
      write_node(6'd0, tbl[i].node0);
      send(tbl[i].feat);
      wait_out(lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("vec%0d_class", i), 32'(out_class), 32'(tbl[i].exp_class));
      chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(tbl[i].exp_err));
`ifdef DTREE_PATHLEN_EN
      chk($sformatf("vec%0d_pathlen", i), 32'(out_pathlen), 32'(tbl[i].exp_lat - 1));
`endif
      release_out();
    end

    // DONE held for 5 cycles; a config write attempted meanwhile is dropped
    write_node(6'd0, mk_node(1'b0, 5'd7, 3'd0, 8'd163, 6'd1, 6'd2));
    f = fset('0, 7, 8'd200);
    send(f);
    wait_out(lat);
    chk("hold_lat", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cfg_we    = (k == 1);
      cfg_addr  = 6'd2;
      cfg_wdata = mk_node(1'b1, 5'd0, 3'd0, 8'd2, 6'd0, 6'd0);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      chk($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_class", k), 32'(out_class), 32'd3);
      chk($sformatf("hold%0d_err", k), 32'(out_err), 32'd0);
      chk($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d_busy", k), 32'(cfg_busy), 32'd1);
    end
    release_out();
    send(f);
    wait_out(lat);
    chk("dropped_wr_class", 32'(out_class), 32'd3);
    release_out();

    // Write and accept in the same idle cycle: traversal sees the new node
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 6'd2;
    cfg_wdata = mk_node(1'b1, 5'd0, 3'd0, 8'd2, 6'd0, 6'd0);
    in_feat   = f;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    wait_out(lat);
    chk("same_cyc_lat", 32'(lat), 32'd2);
    chk("same_cyc_class", 32'(out_class), 32'd2);
    release_out();

    // Reset during a long (looping) walk discards the transaction
    write_node(6'd0, mk_node(1'b0, 5'd0, 3'd0, 8'd0, 6'd0, 6'd0));
    send('0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midwalk_rst_busy", 32'(cfg_busy), 32'd0);
    chk("midwalk_rst_in_ready", 32'(in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      seen_valid = seen_valid | out_valid;
    end
    chk("midwalk_rst_no_valid", 32'(seen_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(f);
    wait_out(lat);
    chk("post_rst_lat", 32'(lat), 32'd1);
    chk("post_rst_class", 32'(out_class), 32'd0);
    chk("post_rst_err", 32'(out_err), 32'd0);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dtree_seq_engine.md
DTREE_SEQ_ENGINE -- requirements
Module: dtree_seq_engine

Interface
REQ-001 SHALL have parameter N_FEAT, default 18, number of input features.
REQ-002 SHALL have parameter FEAT_W, default 8, bits per feature.
REQ-003 SHALL have parameter N_NODES, default 64, node-table entries (node 0 = root).
REQ-004 SHALL have parameter CLASS_W, default 2, class-label width (CLASS_W <= FEAT_W).
REQ-005 SHALL have parameter MAX_STEPS, default 16, traversal step limit.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port in_valid / in_ready  input / output  1 / 1  feature-vector handshake.
REQ-009 SHALL have port in_feat  input  N_FEAT*FEAT_W  feature vector, feature i at bits [i*FEAT_W +: FEAT_W].
REQ-010 SHALL have port out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-011 SHALL have port out_class  output  CLASS_W  predicted class.
REQ-012 SHALL have port out_err  output  1  traversal aborted (step limit or bad child index).
REQ-013 SHALL have port cfg_we / cfg_addr / cfg_wdata  input  1 / clog2(N_NODES) / NODE_W  node-table write port.
REQ-014 SHALL have port cfg_busy  output  1  high whenever state != IDLE.

Function
REQ-015 Node word SHALL be {is_leaf, feat_idx, shift, thr[FEAT_W], left, right}; for a leaf the class is thr[CLASS_W-1:0].
REQ-016 Internal node SHALL go to left if (in_feat[feat_idx] >> shift) <= thr (unsigned), else to right.
REQ-017 FSM SHALL have states IDLE, WALK, DONE; in_ready = (state == IDLE), out_valid = (state == DONE).
REQ-018 IDLE: on in_valid, latch in_feat, node pointer = 0, step count = 0, go to WALK.
REQ-019 WALK SHALL evaluate exactly one node per cycle; on a leaf, latch out_class, clear out_err, go to DONE.
REQ-020 Latency: a leaf reached after n internal nodes SHALL raise out_valid n+1 edges after the accepting edge.
REQ-021 If the step count reaches MAX_STEPS without a leaf, or a child index >= N_NODES is selected, go to DONE with out_class=0, out_err=1.
REQ-022 feat_idx >= N_FEAT SHALL read as feature value 0.
REQ-023 DONE SHALL hold out_class/out_err stable until out_ready, then return to IDLE; no same-cycle input accept.
REQ-024 cfg_we SHALL write the table only in IDLE; writes in WALK/DONE SHALL be dropped.
REQ-025 cfg_we with in_valid in the same IDLE cycle: write SHALL take effect, and the accepted vector SHALL traverse the updated table.

Reset
REQ-026 rst_n low SHALL force IDLE; out_valid=0, in_ready=1 after release, out_class=0, out_err=0, cfg_busy=0.
REQ-027 Reset SHALL load every node-table entry as leaf, class 0.
REQ-028 Reset mid-WALK or mid-DONE SHALL discard the transaction without emitting a result.

Configuration
REQ-029 With macro DTREE_PATHLEN_EN defined, SHALL add output out_pathlen (clog2(MAX_STEPS+1) bits) = internal nodes visited, valid with out_valid, reset 0.
REQ-030 Without DTREE_PATHLEN_EN, out_pathlen SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared package dtree_pkg SHALL hold the node-word struct typedef, the NODE_W/field-width functions, and the FSM state enum.
REQ-032 Node comparison (feature select, shift, compare) SHALL be sub-module dtree_node_eval, purely combinational.

Verification
REQ-033 After reset, send any vector -> out_class=0, out_err=0, out_valid 1 edge after accept.
REQ-034 Load node0={feat 7, shift 0, thr 163, L=1, R=2}, node1=leaf 1, node2=leaf 3; X7=163 -> class 1; X7=164 -> class 3; both 2 edges latency.
REQ-035 Node0 feat 17, shift 3, thr 10: X17=87 (87>>3=10) -> left; X17=88 -> right.
REQ-036 Node0 = internal, L=R=0 -> out_err=1, out_class=0 after MAX_STEPS+1 edges.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, cfg write during that time dropped (readback via later traversal).
REQ-038 Assert rst_n=0 mid-WALK -> no out_valid; next vector traverses reset table -> class 0.
